// File: rtl/scpad_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// scpad_pkg - beat/request types and arbiter states for scpad_dram_req_arbq
// Rev 1.0
// -----------------------------------------------------------------------------
package scpad_pkg;
  localparam int DRAM_ADDR_WIDTH = 32;
  localparam int DRAM_ID_WIDTH   = 4;
  localparam int DRAM_DATA_WIDTH = 32;
  localparam int NBYTES_W        = 3;
  localparam int SUB_W           = 3;
  localparam int CH_W            = 2;

  typedef struct packed {
    logic                       write;
    logic [DRAM_ADDR_WIDTH-1:0] addr;
    logic [DRAM_ID_WIDTH-1:0]   id;
    logic [SUB_W-1:0]           sub_id;
    logic [SUB_W-1:0]           num_request;
    logic [NBYTES_W-1:0]        num_bytes;
    logic [DRAM_DATA_WIDTH-1:0] wdata;
  } dram_beat_t;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    dram_beat_t      beat;
  } dram_req_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/scpad_req_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// scpad_req_fifo - per-channel sync FIFO with flush and show-ahead head
// Rev 1.0
// -----------------------------------------------------------------------------
module scpad_req_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic CLK,
  input  logic nRST,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  T     wdata,
  output T     head,
  output logic full,
  output logic empty
);
  localparam int             c_aw   = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_full = (c_aw + 1)'(DEPTH);

  T                mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_count == c_full);
  assign empty  = (r_count == '0);
  // Flush discards anything offered or taken in the same cycle.
  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;
  assign head   = mem[r_rd_ptr];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) mem[r_wr_ptr] <= wdata;
  end
endmodule
`default_nettype wire

// File: rtl/scpad_dram_req_arbq.sv
`default_nettype none
// -----------------------------------------------------------------------------
// scpad_dram_req_arbq - per-channel request FIFOs with burst-locked RR arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
module scpad_dram_req_arbq
  import scpad_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NUM_CH-1:0]       enq_valid,
  output logic [NUM_CH-1:0]       enq_ready,
  input  dram_beat_t [NUM_CH-1:0] enq_req,
  input  logic [NUM_CH-1:0]       flush,
  output logic                    dram_req_valid,
  output dram_req_t               dram_req,
  input  logic                    dram_ready,
  output logic [NUM_CH-1:0]       burst_complete,
  output logic [NUM_CH-1:0]       queue_empty
);
  localparam int              c_cw   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(NUM_CH - 1);

  arb_state_t              r_state, w_state_nxt;
  logic [c_cw-1:0]         r_rr_ptr, w_rr_nxt;
  logic [c_cw-1:0]         r_lock_ch, w_lock_nxt;
  logic                    r_hold, w_hold_nxt;
  logic [NUM_CH-1:0]       r_done, w_done_nxt;
  logic [c_cw-1:0]         w_grant, w_rr_pick;
  logic [NUM_CH-1:0]       w_full, w_empty, w_pop;
  dram_beat_t [NUM_CH-1:0] w_heads;
  dram_beat_t              w_head;
  logic                    w_valid, w_accept, w_last, w_gflush;
  logic [SUB_W-1:0]        w_nr_eff;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    scpad_req_fifo #(.DEPTH(DEPTH), .T(dram_beat_t)) u_fifo (
      .CLK   (CLK),
      .nRST  (nRST),
      .push  (enq_valid[g]),
      .pop   (w_pop[g]),
      .flush (flush[g]),
      .wdata (enq_req[g]),
      .head  (w_heads[g]),
      .full  (w_full[g]),
      .empty (w_empty[g])
    );
  end

  assign enq_ready      = ~w_full;
  assign queue_empty    = w_empty;
  assign burst_complete = r_done;

  // Lowest non-empty channel overall, overridden by the lowest at/after rr_ptr.
  always_comb begin
    w_rr_pick = r_rr_ptr;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (!w_empty[c]) w_rr_pick = c_cw'(c);
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (!w_empty[c] && (c_cw'(c) >= r_rr_ptr)) w_rr_pick = c_cw'(c);
  end

  // r_lock_ch doubles as the frozen grant while a stalled beat is held in IDLE.
  assign w_grant  = ((r_state == ARB_LOCKED) || r_hold) ? r_lock_ch : w_rr_pick;
  assign w_valid  = !w_empty[w_grant];
  assign w_head   = w_heads[w_grant];
  assign w_accept = w_valid && dram_ready;
  assign w_gflush = flush[w_grant];
  assign w_nr_eff = (w_head.num_request == '0) ? SUB_W'(1) : w_head.num_request;
  assign w_last   = (w_nr_eff == SUB_W'(1)) || (w_head.sub_id == w_nr_eff - SUB_W'(1));

  assign dram_req_valid = w_valid;

  always_comb begin
    dram_req = '0;
    if (w_valid) begin
      dram_req.ch   = CH_W'(w_grant);
      dram_req.beat = w_head;
    end
  end

  always_comb begin
    w_pop = '0;
    w_pop[w_grant] = w_accept;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_lock_nxt  = r_lock_ch;
    w_hold_nxt  = 1'b0;
    w_done_nxt  = '0;
    if (w_accept && w_last) begin
      w_state_nxt         = ARB_IDLE;
      w_rr_nxt            = (w_grant == c_last) ? '0 : w_grant + 1'b1;
      w_done_nxt[w_grant] = 1'b1;
    end else if (r_state == ARB_LOCKED) begin
      if (w_gflush) w_state_nxt = ARB_IDLE;
    end else if (w_accept) begin
      if (!w_gflush) begin
        w_state_nxt = ARB_LOCKED;
        w_lock_nxt  = w_grant;
      end
    end else if (w_valid && !w_gflush) begin
      w_hold_nxt = 1'b1;
      w_lock_nxt = w_grant;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= ARB_IDLE;
      r_rr_ptr  <= '0;
      r_lock_ch <= '0;
      r_hold    <= 1'b0;
      r_done    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_lock_ch <= w_lock_nxt;
      r_hold    <= w_hold_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // A multi-beat burst must open with sub_id 0.
  always_ff @(posedge CLK) begin
    if (nRST && w_accept && (r_state == ARB_IDLE) && !w_last)
      assert (w_head.sub_id == '0);
  end
endmodule
`default_nettype wire

// File: tb/tb_scpad_dram_req_arbq.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_scpad_dram_req_arbq - random stimulus against a queue-based arbiter model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_scpad_dram_req_arbq;
  import scpad_pkg::*;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 8;

  logic                    CLK = 1'b0;
  logic                    nRST = 1'b1;
  logic [NUM_CH-1:0]       enq_valid = '0;
  logic [NUM_CH-1:0]       enq_ready;
  dram_beat_t [NUM_CH-1:0] enq_req = '0;
  logic [NUM_CH-1:0]       flush = '0;
  logic                    dram_req_valid;
  dram_req_t               dram_req;
  logic                    dram_ready = 1'b0;
  logic [NUM_CH-1:0]       burst_complete;
  logic [NUM_CH-1:0]       queue_empty;

  scpad_dram_req_arbq #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .enq_valid      (enq_valid),
    .enq_ready      (enq_ready),
    .enq_req        (enq_req),
    .flush          (flush),
    .dram_req_valid (dram_req_valid),
    .dram_req       (dram_req),
    .dram_ready     (dram_ready),
    .burst_complete (burst_complete),
    .queue_empty    (queue_empty)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h @%0t", name, act, want, $time);
    end
  endtask

  // Reference model: each channel is just the list of beats it still holds.
  dram_beat_t        mq [NUM_CH][$];
  bit                m_lock;
  int                m_lock_ch;
  int                m_rr;
  bit                m_hold;
  int                m_hold_ch;
  logic [NUM_CH-1:0] m_done;

  initial begin : monitor
    forever begin
      int                g;
      int                nr;
      bit                ev, acc, last, was_lock;
      bit                ok_enq [NUM_CH];
      logic [NUM_CH-1:0] new_done;
      dram_beat_t        b;
      dram_req_t         want;
      @(negedge CLK);
      if (!nRST) begin
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        m_lock = 0; m_rr = 0; m_hold = 0; m_done = '0;
      end else begin
        if (m_lock) g = m_lock_ch;
        else if (m_hold) g = m_hold_ch;
        else begin
          g = m_rr;
          for (int i = 0; i < NUM_CH; i++)
            if (mq[(m_rr + i) % NUM_CH].size() > 0) begin
              g = (m_rr + i) % NUM_CH;
              break;
            end
        end
        ev = mq[g].size() > 0;

        for (int c = 0; c < NUM_CH; c++) begin
          ok_enq[c] = mq[c].size() < DEPTH;
          check("enq_ready", 128'(enq_ready[c]), 128'(ok_enq[c]));
          check("queue_empty", 128'(queue_empty[c]), 128'(mq[c].size() == 0));
        end
        check("dram_req_valid", 128'(dram_req_valid), 128'(ev));
        if (ev) begin
          want.ch   = CH_W'(g);
          want.beat = mq[g][0];
          check("dram_req", 128'(dram_req), 128'(want));
        end
        check("burst_complete", 128'(burst_complete), 128'(m_done));

        acc      = ev && dram_ready;
        last     = 0;
        was_lock = m_lock;
        new_done = '0;
        if (acc) begin
          b    = mq[g].pop_front();
          nr   = (b.num_request == 0) ? 1 : int'(b.num_request);
          last = (nr == 1) || (int'(b.sub_id) == nr - 1);
        end
        if (acc && last) begin
          new_done[g] = 1'b1;
          m_lock      = 0;
          m_rr        = (g + 1) % NUM_CH;
        end else if (m_lock) begin
          if (flush[m_lock_ch]) m_lock = 0;
        end else if (acc && !flush[g]) begin
          m_lock    = 1;
          m_lock_ch = g;
        end
        m_hold    = !was_lock && ev && !dram_ready && !flush[g];
        m_hold_ch = g;
        for (int c = 0; c < NUM_CH; c++) begin
          if (flush[c]) mq[c].delete();
          else if (enq_valid[c] && ok_enq[c]) mq[c].push_back(enq_req[c]);
        end
        m_done = new_done;
      end
    end
  end

  int g_nr  [NUM_CH];
  int g_sub [NUM_CH];

  function automatic dram_beat_t rand_beat(int sub, int nr);
    dram_beat_t b;
    b.write       = 1'($urandom_range(1));
    b.addr        = DRAM_ADDR_WIDTH'($urandom);
    b.id          = DRAM_ID_WIDTH'($urandom);
    b.sub_id      = SUB_W'(sub);
    b.num_request = SUB_W'(nr);
    b.num_bytes   = NBYTES_W'($urandom);
    b.wdata       = DRAM_DATA_WIDTH'($urandom);
    return b;
  endfunction

  // One cycle of burst-structured random traffic; inputs change 1 after posedge.
  task automatic step(input int p_enq, input int p_rdy, input int p_fl);
    logic [NUM_CH-1:0] hs, fl;
    for (int c = 0; c < NUM_CH; c++) begin
      if (g_sub[c] == 0) g_nr[c] = int'($urandom_range(7));
      enq_req[c]   = rand_beat(g_sub[c], g_nr[c]);
      enq_valid[c] = $urandom_range(99) < p_enq;
      flush[c]     = $urandom_range(999) < p_fl;
    end
    dram_ready = $urandom_range(99) < p_rdy;
    @(negedge CLK);
    hs = enq_valid & enq_ready & ~flush;
    fl = flush;
    @(posedge CLK); #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (fl[c]) g_sub[c] = 0;
      else if (hs[c]) begin
        g_sub[c]++;
        if (g_sub[c] >= ((g_nr[c] == 0) ? 1 : g_nr[c])) g_sub[c] = 0;
      end
    end
  endtask

  task automatic check_reset_outputs();
    logic [NUM_CH-1:0] ones;
    ones = '1;
    check("rst_dram_req_valid", 128'(dram_req_valid), 128'(0));
    check("rst_dram_req", 128'(dram_req), 128'(0));
    check("rst_burst_complete", 128'(burst_complete), 128'(0));
    check("rst_queue_empty", 128'(queue_empty), 128'(ones));
    check("rst_enq_ready", 128'(enq_ready), 128'(ones));
  endtask

  initial begin : stimulus
    dram_beat_t b;
    for (int c = 0; c < NUM_CH; c++) begin g_nr[c] = 0; g_sub[c] = 0; end
    #1 nRST = 1'b0;
    #2 check_reset_outputs();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Single write beat on ch0.
    b = '0;
    b.write = 1'b1; b.addr = 32'h1000; b.num_request = 3'd1;
    enq_req[0] = b; enq_valid[0] = 1'b1; dram_ready = 1'b1;
    @(posedge CLK); #1;
    enq_valid = '0;
    repeat (4) @(posedge CLK); #1;

    // Fill ch1 while the controller stalls, then drain in order.
    dram_ready = 1'b0;
    for (int k = 0; k < DEPTH + 5; k++) begin
      enq_req[1]   = rand_beat(0, 1);
      enq_valid[1] = 1'b1;
      @(posedge CLK); #1;
    end
    check("fill_enq_ready", 128'(enq_ready[1]), 128'(0));
    enq_valid  = '0;
    dram_ready = 1'b1;
    repeat (DEPTH + 3) @(posedge CLK); #1;

    repeat (400) step(60, 100, 0);
    repeat (400) step(80, 20, 0);
    repeat (600) step(70, 60, 8);
    repeat (400) step(30, 90, 2);

    // Asynchronous reset in the middle of a locked burst.
    for (int k = 0; k < 300 && !m_lock; k++) step(70, 50, 0);
    #2 nRST = 1'b0;
    enq_valid = '0;
    flush     = '0;
    #1 check_reset_outputs();
    @(negedge CLK);
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int c = 0; c < NUM_CH; c++) g_sub[c] = 0;

    repeat (300) step(60, 70, 5);
    enq_valid = '0;
    flush     = '0;
    repeat (4) @(posedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
